// File: rtl/bilinear_pkg.sv
// Shared types and constants for the bilinear scaling sequencer.
package bilinear_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ROW,
        ST_ADDR,
        ST_RD,
        ST_CALC,
        ST_WR,
        ST_DONE
    } state_e;

    localparam int FRAC_W          = 8;
    localparam int FLOPS_PER_PIXEL = 8;
    localparam int RD_PER_PIXEL    = 4;
    localparam int STEP_ENTRIES    = 11;

    // Source step per output pixel for scale = 128 + 13*k, i.e. round(65536/scale)
    localparam logic [15:0] STEP_LUT [STEP_ENTRIES] = '{
        16'd512, 16'd465, 16'd426, 16'd392, 16'd364, 16'd340,
        16'd318, 16'd299, 16'd282, 16'd267, 16'd254
    };

    function automatic logic [15:0] step_lookup(input logic [15:0] scale);
        logic [15:0] step;
        step = 16'd256;
        for (int k = 0; k < STEP_ENTRIES; k++) begin
            if (scale == 16'(128 + 13 * k)) begin
                step = STEP_LUT[k];
            end
        end
        return step;
    endfunction

    function automatic logic [15:0] clamp_idx(input logic [15:0] v, input logic [15:0] last);
        return (v > last) ? last : v;
    endfunction

    function automatic logic [15:0] next_idx(input logic [15:0] v, input logic [15:0] last);
        return (v >= last) ? last : v + 16'd1;
    endfunction

endpackage

// File: rtl/bilinear_seq_ctrl_if.sv
// Memory-side bus of the sequencer: input BRAM read port and output BRAM write port.
interface bilinear_seq_ctrl_if #(
    parameter int AW    = 12,
    parameter int PIX_W = 8
);
    logic [AW-1:0]    in_mem_raddr;
    logic [PIX_W-1:0] in_mem_rdata;
    logic [AW-1:0]    out_mem_waddr;
    logic [PIX_W-1:0] out_mem_wdata;
    logic             out_mem_we;

    modport master (
        output in_mem_raddr,
        input  in_mem_rdata,
        output out_mem_waddr,
        output out_mem_wdata,
        output out_mem_we
    );

    modport slave (
        input  in_mem_raddr,
        output in_mem_rdata,
        input  out_mem_waddr,
        input  out_mem_wdata,
        input  out_mem_we
    );
endinterface

// File: rtl/bilinear_pe.sv
// Combinational Q8.8 bilinear interpolator: four neighbours plus fx/fy in, rounded and saturated pixel out.
module bilinear_pe
    import bilinear_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0]  p00,
    input  logic [PIX_W-1:0]  p01,
    input  logic [PIX_W-1:0]  p10,
    input  logic [PIX_W-1:0]  p11,
    input  logic [FRAC_W-1:0] fx,
    input  logic [FRAC_W-1:0] fy,
    output logic [PIX_W-1:0]  pix
);
    localparam int SW = PIX_W + 2 * FRAC_W + 2;
    localparam logic [PIX_W-1:0] PIX_MAX = {PIX_W{1'b1}};

    logic [SW-1:0] wfx0, wfx1, wfy0, wfy1;
    logic [SW-1:0] h0, h1, sum, shifted;

    always_comb begin
        wfx1    = SW'(fx);
        wfx0    = SW'(1 << FRAC_W) - wfx1;
        wfy1    = SW'(fy);
        wfy0    = SW'(1 << FRAC_W) - wfy1;
        h0      = SW'(p00) * wfx0 + SW'(p01) * wfx1;
        h1      = SW'(p10) * wfx0 + SW'(p11) * wfx1;
        // Half an LSB of the 2*FRAC_W fraction gives round-to-nearest
        sum     = h0 * wfy0 + h1 * wfy1 + SW'(1 << (2 * FRAC_W - 1));
        shifted = sum >> (2 * FRAC_W);
        pix     = (shifted > SW'(PIX_MAX)) ? PIX_MAX : shifted[PIX_W-1:0];
    end
endmodule

// File: rtl/bilinear_seq_ctrl.sv
// Bilinear scaling sequencer: walks output pixels, fetches 4 neighbours, interpolates, writes back.
// Optional BSEQ_CFG_CHECK_EN rejects images larger than the 2^AW address space.
module bilinear_seq_ctrl
    import bilinear_pkg::*;
#(
    parameter int AW    = 12,
    parameter int PIX_W = 8
) (
    input  logic                clk_sys,
    input  logic                rst_sys,
    input  logic                start_pulse,
    input  logic [15:0]         cfg_in_w,
    input  logic [15:0]         cfg_in_h,
    input  logic [15:0]         cfg_scale_q88,
    bilinear_seq_ctrl_if.master mem,
    output logic                status_busy,
    output logic                status_done,
    output logic                status_error,
    output logic [31:0]         perf_flops,
    output logic [31:0]         perf_mem_rd,
    output logic [31:0]         perf_mem_wr
);
    localparam logic [2:0] RD_LAST = 3'(RD_PER_PIXEL);

    state_e           state_q, state_d;
    logic             pulse_q;
    logic [15:0]      in_w_q, in_w_d, in_h_q, in_h_d, scale_q, scale_d;
    logic [15:0]      out_w_q, out_w_d, out_h_q, out_h_d, step_q, step_d;
    logic [15:0]      ox_q, ox_d, oy_q, oy_d;
    logic [23:0]      sx_q, sx_d, sy_q, sy_d;
    logic [15:0]      x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [7:0]       fx_q, fx_d, fy_q, fy_d;
    logic [2:0]       rd_cnt_q, rd_cnt_d;
    logic [PIX_W-1:0] p_q [4];
    logic [PIX_W-1:0] p_d [4];
    logic [PIX_W-1:0] res_q, res_d, pe_pix;
    logic [AW-1:0]    out_idx_q, out_idx_d;
    logic [31:0]      flops_q, flops_d, rd_q, rd_d, wr_q, wr_d;
    logic             start_evt;
    logic [1:0]       cap_idx;
    logic [15:0]      row_sel, col_sel;
`ifdef BSEQ_CFG_CHECK_EN
    logic             error_q, error_d;
    assign status_error = error_q;
`else
    assign status_error = 1'b0;
`endif

    assign start_evt   = start_pulse & ~pulse_q;
    assign cap_idx     = rd_cnt_q[1:0] - 2'd1;
    assign row_sel     = rd_cnt_q[1] ? y1_q : y0_q;
    assign col_sel     = rd_cnt_q[0] ? x1_q : x0_q;
    assign status_busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign status_done = (state_q == ST_DONE);
    assign perf_flops  = flops_q;
    assign perf_mem_rd = rd_q;
    assign perf_mem_wr = wr_q;

    bilinear_pe #(.PIX_W(PIX_W)) u_pe (
        .p00(p_q[0]), .p01(p_q[1]), .p10(p_q[2]), .p11(p_q[3]),
        .fx(fx_q), .fy(fy_q), .pix(pe_pix)
    );

    always_comb begin
        mem.in_mem_raddr  = '0;
        mem.out_mem_waddr = '0;
        mem.out_mem_wdata = '0;
        mem.out_mem_we    = 1'b0;
        if (state_q == ST_RD && rd_cnt_q < RD_LAST) begin
            mem.in_mem_raddr = AW'(32'(row_sel) * 32'(in_w_q) + 32'(col_sel));
        end
        if (state_q == ST_WR) begin
            mem.out_mem_waddr = out_idx_q;
            mem.out_mem_wdata = res_q;
            mem.out_mem_we    = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        in_w_d = in_w_q;  in_h_d = in_h_q;  scale_d = scale_q;
        out_w_d = out_w_q; out_h_d = out_h_q; step_d = step_q;
        ox_d = ox_q; oy_d = oy_q; sx_d = sx_q; sy_d = sy_q;
        x0_d = x0_q; x1_d = x1_q; y0_d = y0_q; y1_d = y1_q;
        fx_d = fx_q; fy_d = fy_q; rd_cnt_d = rd_cnt_q;
        p_d = p_q; res_d = res_q; out_idx_d = out_idx_q;
        flops_d = flops_q; rd_d = rd_q; wr_d = wr_q;
`ifdef BSEQ_CFG_CHECK_EN
        error_d = error_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_evt) begin
                    state_d = ST_SETUP;
                    in_w_d = cfg_in_w; in_h_d = cfg_in_h; scale_d = cfg_scale_q88;
                    ox_d = '0; oy_d = '0; sx_d = '0; sy_d = '0; out_idx_d = '0;
                    flops_d = '0; rd_d = '0; wr_d = '0;
`ifdef BSEQ_CFG_CHECK_EN
                    error_d = 1'b0;
`endif
                end
            end
            ST_SETUP: begin
                out_w_d = 16'((32'(in_w_q) * 32'(scale_q)) >> FRAC_W);
                out_h_d = 16'((32'(in_h_q) * 32'(scale_q)) >> FRAC_W);
                step_d  = step_lookup(scale_q);
                if (in_w_q == '0 || in_h_q == '0 || out_w_d == '0 || out_h_d == '0) begin
                    state_d = ST_DONE;
`ifdef BSEQ_CFG_CHECK_EN
                end else if ({1'b0, 32'(in_w_q) * 32'(in_h_q)} > (33'd1 << AW) ||
                             {1'b0, 32'(out_w_d) * 32'(out_h_d)} > (33'd1 << AW)) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_ROW;
                end
            end
            ST_ROW: begin
                sx_d    = '0;
                y0_d    = clamp_idx(sy_q[23:8], in_h_q - 16'd1);
                y1_d    = next_idx(y0_d, in_h_q - 16'd1);
                fy_d    = sy_q[7:0];
                state_d = ST_ADDR;
            end
            ST_ADDR: begin
                x0_d     = clamp_idx(sx_q[23:8], in_w_q - 16'd1);
                x1_d     = next_idx(x0_d, in_w_q - 16'd1);
                fx_d     = sx_q[7:0];
                rd_cnt_d = '0;
                state_d  = ST_RD;
            end
            ST_RD: begin
                // Read data trails the issued address by one cycle
                if (rd_cnt_q < RD_LAST) begin
                    rd_d = rd_q + 32'd1;
                end
                if (rd_cnt_q != '0) begin
                    p_d[cap_idx] = mem.in_mem_rdata;
                end
                if (rd_cnt_q == RD_LAST) begin
                    state_d = ST_CALC;
                end else begin
                    rd_cnt_d = rd_cnt_q + 3'd1;
                end
            end
            ST_CALC: begin
                res_d   = pe_pix;
                state_d = ST_WR;
            end
            ST_WR: begin
                wr_d      = wr_q + 32'd1;
                flops_d   = flops_q + 32'(FLOPS_PER_PIXEL);
                out_idx_d = out_idx_q + 1'b1;
                if (ox_q == out_w_q - 16'd1) begin
                    if (oy_q == out_h_q - 16'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        ox_d    = '0;
                        oy_d    = oy_q + 16'd1;
                        sx_d    = '0;
                        sy_d    = sy_q + 24'(step_q);
                        state_d = ST_ROW;
                    end
                end else begin
                    ox_d    = ox_q + 16'd1;
                    sx_d    = sx_q + 24'(step_q);
                    state_d = ST_ADDR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q <= ST_IDLE;
            pulse_q <= 1'b0;
            in_w_q <= '0; in_h_q <= '0; scale_q <= '0;
            out_w_q <= '0; out_h_q <= '0; step_q <= '0;
            ox_q <= '0; oy_q <= '0; sx_q <= '0; sy_q <= '0;
            x0_q <= '0; x1_q <= '0; y0_q <= '0; y1_q <= '0;
            fx_q <= '0; fy_q <= '0; rd_cnt_q <= '0;
            p_q <= '{default: '0};
            res_q <= '0; out_idx_q <= '0;
            flops_q <= '0; rd_q <= '0; wr_q <= '0;
`ifdef BSEQ_CFG_CHECK_EN
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pulse_q <= start_pulse;
            in_w_q <= in_w_d; in_h_q <= in_h_d; scale_q <= scale_d;
            out_w_q <= out_w_d; out_h_q <= out_h_d; step_q <= step_d;
            ox_q <= ox_d; oy_q <= oy_d; sx_q <= sx_d; sy_q <= sy_d;
            x0_q <= x0_d; x1_q <= x1_d; y0_q <= y0_d; y1_q <= y1_d;
            fx_q <= fx_d; fy_q <= fy_d; rd_cnt_q <= rd_cnt_d;
            p_q <= p_d;
            res_q <= res_d; out_idx_q <= out_idx_d;
            flops_q <= flops_d; rd_q <= rd_d; wr_q <= wr_d;
`ifdef BSEQ_CFG_CHECK_EN
            error_q <= error_d;
`endif
        end
    end
endmodule

// File: tb/tb_bilinear_seq_ctrl.sv
// Directed self-checking bench for bilinear_seq_ctrl with behavioural input/output BRAMs.
// Define BSEQ_CFG_CHECK_EN for both RTL and bench to exercise the oversize-config check.
module tb_bilinear_seq_ctrl;
    localparam int AW    = 12;
    localparam int PIX_W = 8;

    logic        clk_sys = 1'b0;
    logic        rst_sys;
    logic        start_pulse;
    logic [15:0] cfg_in_w, cfg_in_h, cfg_scale_q88;
    logic        status_busy, status_done, status_error;
    logic [31:0] perf_flops, perf_mem_rd, perf_mem_wr;

    logic [PIX_W-1:0] src_mem [1 << AW];
    logic [PIX_W-1:0] dst_mem [1 << AW];
    int wr_seen     = 0;
    int busy_cycles = 0;
    int checks      = 0;
    int errors      = 0;

    always #5 clk_sys = ~clk_sys;

    bilinear_seq_ctrl_if #(.AW(AW), .PIX_W(PIX_W)) mem_if ();

    bilinear_seq_ctrl #(.AW(AW), .PIX_W(PIX_W)) u_dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .start_pulse(start_pulse),
        .cfg_in_w(cfg_in_w), .cfg_in_h(cfg_in_h), .cfg_scale_q88(cfg_scale_q88),
        .mem(mem_if),
        .status_busy(status_busy), .status_done(status_done), .status_error(status_error),
        .perf_flops(perf_flops), .perf_mem_rd(perf_mem_rd), .perf_mem_wr(perf_mem_wr)
    );

    // Registered-read source BRAM and write-only destination BRAM
    always @(posedge clk_sys) begin
        mem_if.in_mem_rdata <= src_mem[mem_if.in_mem_raddr];
        if (mem_if.out_mem_we) begin
            dst_mem[mem_if.out_mem_waddr] <= mem_if.out_mem_wdata;
            wr_seen <= wr_seen + 1;
        end
    end

    always @(negedge clk_sys) begin
        if (status_busy) busy_cycles <= busy_cycles + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic pulseStart(input int hold);
        @(negedge clk_sys);
        start_pulse = 1'b1;
        repeat (hold) @(negedge clk_sys);
        start_pulse = 1'b0;
    endtask

    task automatic applyStimulus(input int w, input int h, input int scale, input int hold);
        cfg_in_w      = 16'(w);
        cfg_in_h      = 16'(h);
        cfg_scale_q88 = 16'(scale);
        pulseStart(hold);
    endtask

    task automatic waitDone(input string tag);
        for (int i = 0; i < 2000; i++) begin
            if (status_done) break;
            @(negedge clk_sys);
        end
        checkOutput({tag, "_done"}, 32'(status_done), 32'd1);
    endtask

    task automatic loadRamp();
        for (int r = 0; r < 2; r++) begin
            src_mem[r*4+0] = 8'd0;   src_mem[r*4+1] = 8'd100;
            src_mem[r*4+2] = 8'd200; src_mem[r*4+3] = 8'd255;
        end
    endtask

    initial begin
        int b0, w0;
        rst_sys = 1'b1; start_pulse = 1'b0;
        cfg_in_w = '0; cfg_in_h = '0; cfg_scale_q88 = '0;
        repeat (3) @(negedge clk_sys);
        checkOutput("rst_busy",  32'(status_busy), 32'd0);
        checkOutput("rst_done",  32'(status_done), 32'd0);
        checkOutput("rst_err",   32'(status_error), 32'd0);
        checkOutput("rst_we",    32'(mem_if.out_mem_we), 32'd0);
        checkOutput("rst_flops", perf_flops, 32'd0);
        rst_sys = 1'b0;

        // 2x2 identity scale
        src_mem[0] = 8'd10; src_mem[1] = 8'd20; src_mem[2] = 8'd30; src_mem[3] = 8'd40;
        b0 = busy_cycles;
        applyStimulus(2, 2, 256, 1);
        waitDone("t1");
        checkOutput("t1_px0", 32'(dst_mem[0]), 32'd10);
        checkOutput("t1_px1", 32'(dst_mem[1]), 32'd20);
        checkOutput("t1_px2", 32'(dst_mem[2]), 32'd30);
        checkOutput("t1_px3", 32'(dst_mem[3]), 32'd40);
        checkOutput("t1_rd",    perf_mem_rd, 32'd16);
        checkOutput("t1_wr",    perf_mem_wr, 32'd4);
        checkOutput("t1_flops", perf_flops,  32'd32);
        checkOutput("t1_busy",  32'(status_busy), 32'd0);
        checkOutput("t1_busy_cycles", 32'(busy_cycles - b0), 32'd35);
        checkOutput("t1_err",   32'(status_error), 32'd0);

        // 4x1 downscale: out_h truncates to 0, nothing is written
        loadRamp();
        w0 = wr_seen;
        applyStimulus(4, 1, 128, 1);
        waitDone("t2a");
        checkOutput("t2a_wr",    perf_mem_wr, 32'd0);
        checkOutput("t2a_rd",    perf_mem_rd, 32'd0);
        checkOutput("t2a_we_seen", 32'(wr_seen - w0), 32'd0);

        applyStimulus(4, 2, 128, 1);
        waitDone("t2b");
        checkOutput("t2b_px0", 32'(dst_mem[0]), 32'd0);
        checkOutput("t2b_px1", 32'(dst_mem[1]), 32'd200);
        checkOutput("t2b_wr",  perf_mem_wr, 32'd2);
        checkOutput("t2b_rd",  perf_mem_rd, 32'd8);

        // Scale 258: second pixel sits at fx=254
        src_mem[0] = 8'd0; src_mem[1] = 8'd255;
        applyStimulus(2, 1, 258, 1);
        waitDone("t3");
        checkOutput("t3_px0", 32'(dst_mem[0]), 32'd0);
        checkOutput("t3_px1", 32'(dst_mem[1]), 32'd253);
        checkOutput("t3_wr",  perf_mem_wr, 32'd2);

        // Long start level plus a retrigger mid-run gives one run
        src_mem[0] = 8'd10; src_mem[1] = 8'd20; src_mem[2] = 8'd30; src_mem[3] = 8'd40;
        w0 = wr_seen;
        applyStimulus(2, 2, 256, 8);
        repeat (3) @(negedge clk_sys);
        pulseStart(2);
        waitDone("t4");
        repeat (10) @(negedge clk_sys);
        checkOutput("t4_we_seen", 32'(wr_seen - w0), 32'd4);
        checkOutput("t4_wr",      perf_mem_wr, 32'd4);
        checkOutput("t4_done",    32'(status_done), 32'd1);

        // Restart from DONE clears counters and runs again
        src_mem[0] = 8'd1; src_mem[1] = 8'd2; src_mem[2] = 8'd3; src_mem[3] = 8'd4;
        applyStimulus(2, 2, 256, 1);
        checkOutput("t4b_wr_clr",   perf_mem_wr, 32'd0);
        checkOutput("t4b_done_clr", 32'(status_done), 32'd0);
        waitDone("t4b");
        checkOutput("t4b_px0", 32'(dst_mem[0]), 32'd1);
        checkOutput("t4b_px3", 32'(dst_mem[3]), 32'd4);
        checkOutput("t4b_wr",  perf_mem_wr, 32'd4);
        checkOutput("t4b_rd",  perf_mem_rd, 32'd16);

        // Reset during the fourth pixel's reads aborts the run
        loadRamp();
        w0 = wr_seen;
        applyStimulus(4, 2, 256, 1);
        for (int i = 0; i < 500; i++) begin
            if (wr_seen - w0 >= 3) break;
            @(negedge clk_sys);
        end
        checkOutput("t5_three_writes", 32'(wr_seen - w0), 32'd3);
        repeat (2) @(negedge clk_sys);
        rst_sys = 1'b1;
        @(negedge clk_sys);
        checkOutput("t5_busy",  32'(status_busy), 32'd0);
        checkOutput("t5_done",  32'(status_done), 32'd0);
        checkOutput("t5_we",    32'(mem_if.out_mem_we), 32'd0);
        checkOutput("t5_raddr", 32'(mem_if.in_mem_raddr), 32'd0);
        checkOutput("t5_rd",    perf_mem_rd, 32'd0);
        checkOutput("t5_wr",    perf_mem_wr, 32'd0);
        checkOutput("t5_flops", perf_flops,  32'd0);
        @(negedge clk_sys);
        rst_sys = 1'b0;
        repeat (20) @(negedge clk_sys);
        checkOutput("t5_no_more_we", 32'(wr_seen - w0), 32'd3);
        checkOutput("t5_idle",       32'(status_busy), 32'd0);

`ifdef BSEQ_CFG_CHECK_EN
        applyStimulus(128, 128, 256, 1);
        waitDone("t6");
        checkOutput("t6_err", 32'(status_error), 32'd1);
        checkOutput("t6_rd",  perf_mem_rd, 32'd0);
        checkOutput("t6_wr",  perf_mem_wr, 32'd0);
        applyStimulus(2, 2, 256, 1);
        checkOutput("t6_err_clr", 32'(status_error), 32'd0);
        waitDone("t6b");
`else
        checkOutput("t6_err_off", 32'(status_error), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
